// File: rtl/q_ms_writer.sv
// Measurement-result writer: pairs queued measure requests with readout bits
// and drives the two-phase address/data write into the measurement regfile.
module q_ms_writer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     meas_req,
  input  logic [4:0]               meas_qubit,
  output logic                     meas_ready,
  input  logic                     res_valid,
  input  logic                     res_bit,
  output logic                     wr_en,
  output logic [4:0]               wr_addr,
  output logic                     wr_valid,
  output logic                     wr_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     busy,
  output logic                     err_orphan,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [4:0]    r_amem [DEPTH];
  logic          r_rmem [DEPTH];
  logic [AW-1:0] r_awp;
  logic [AW-1:0] r_arp;
  logic [AW-1:0] r_rwp;
  logic [AW-1:0] r_rrp;
  logic [CW-1:0] r_acnt;
  logic [CW-1:0] r_rcnt;
  logic [CW-1:0] r_out;
  logic [2:0]    r_st;
  logic          r_wr_en;
  logic [4:0]    r_wr_addr;
  logic          r_wr_valid;
  logic          r_wr_data;
  logic          r_err;

  logic w_afull;
  logic w_aempty;
  logic w_rempty;
  logic w_acc;
  logic w_res_ok;
  logic w_orphan;
  logic w_pop;

  assign w_afull  = (r_acnt == FULL);
  assign w_aempty = (r_acnt == '0);
  assign w_rempty = (r_rcnt == '0);
  assign w_acc    = meas_req & ~w_afull;
  // a result pairs if something is outstanding or a request lands this cycle
  assign w_res_ok = res_valid & ((r_out != '0) | w_acc);
  assign w_orphan = res_valid & ~w_res_ok;
  assign w_pop    = (r_st == S_DATA);

  always_ff @(posedge clk) begin
    if (w_acc) r_amem[r_awp] <= meas_qubit;
    if (w_res_ok) r_rmem[r_rwp] <= res_bit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_awp  <= '0;
      r_arp  <= '0;
      r_rwp  <= '0;
      r_rrp  <= '0;
      r_acnt <= '0;
      r_rcnt <= '0;
      r_out  <= '0;
    end else begin
      if (w_acc) r_awp <= r_awp + 1'b1;
      if (w_res_ok) r_rwp <= r_rwp + 1'b1;
      if (w_pop) begin
        r_arp <= r_arp + 1'b1;
        r_rrp <= r_rrp + 1'b1;
      end
      r_acnt <= r_acnt + CW'(w_acc) - CW'(w_pop);
      r_rcnt <= r_rcnt + CW'(w_res_ok) - CW'(w_pop);
      r_out  <= r_out + CW'(w_acc) - CW'(w_res_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st       <= S_IDLE;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_valid <= 1'b0;
      r_wr_data  <= 1'b0;
    end else begin
      unique case (r_st)
        S_IDLE: begin
          if (!w_aempty) begin
            r_st      <= S_ADDR;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_amem[r_arp];
          end
        end
        S_ADDR: begin
          r_st    <= S_WAIT;
          r_wr_en <= 1'b0;
        end
        S_WAIT: begin
          if (!w_rempty) begin
            r_st       <= S_DATA;
            r_wr_valid <= 1'b1;
            r_wr_data  <= r_rmem[r_rrp];
          end
        end
        S_DATA: begin
          r_st       <= S_GAP;
          r_wr_valid <= 1'b0;
        end
        S_GAP: begin
          // count already reflects the pop done on leaving DATA
          if (!w_aempty) begin
            r_st      <= S_ADDR;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_amem[r_arp];
          end else begin
            r_st <= S_IDLE;
          end
        end
        default: begin
          r_st       <= S_IDLE;
          r_wr_en    <= 1'b0;
          r_wr_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else if (w_orphan) r_err <= 1'b1;
    else if (err_clr) r_err <= 1'b0;
  end

  assign meas_ready = ~w_afull;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_valid   = r_wr_valid;
  assign wr_data    = r_wr_data;
  assign pending    = r_acnt;
  assign busy       = (r_acnt != '0) | (r_st != S_IDLE);
  assign err_orphan = r_err;

endmodule

// File: tb/tb_q_ms_writer.sv
// Scoreboard bench for q_ms_writer: directed requests/results, monitor
// pops expected (addr,bit) pairs on every data-phase strobe.
module tb_q_ms_writer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset_n;
  logic       meas_req;
  logic [4:0] meas_qubit;
  logic       meas_ready;
  logic       res_valid;
  logic       res_bit;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic       wr_valid;
  logic       wr_data;
  logic [$clog2(DEPTH):0] pending;
  logic       busy;
  logic       err_orphan;
  logic       err_clr;

  q_ms_writer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .meas_req   (meas_req),
    .meas_qubit (meas_qubit),
    .meas_ready (meas_ready),
    .res_valid  (res_valid),
    .res_bit    (res_bit),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .pending    (pending),
    .busy       (busy),
    .err_orphan (err_orphan),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] a;
    logic       d;
  } wr_t;

  wr_t        exp_q[$];
  int         en_stamps[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_val = 0;
  int         cyc = 0;
  logic [4:0] seen_addr = '0;
  wr_t        m_e;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req,
               $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && (wr_en || wr_valid)) begin
      chk("no_overlap", {31'b0, wr_en & wr_valid}, 32'd0);
      if (wr_en) begin
        seen_addr = wr_addr;
        en_stamps.push_back(cyc);
      end
      if (wr_valid) begin
        n_val++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", exp_q.size(), 32'd1);
        end else begin
          m_e = exp_q.pop_front();
          chk("wr_addr", {27'b0, seen_addr}, {27'b0, m_e.a});
          chk("wr_data", {31'b0, wr_data}, {31'b0, m_e.d});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [4:0] q, input logic b);
    int i;
    exp_q.push_back('{a: q, d: b});
    meas_qubit = q;
    meas_req   = 1'b1;
    i = 0;
    while (!meas_ready && i < 100) begin
      tick();
      i++;
    end
    if (i >= 100) chk("req_accept_timeout", {31'b0, meas_ready}, 32'd1);
    tick();
    meas_req = 1'b0;
  endtask

  task automatic send_res(input logic b);
    res_bit   = b;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (!busy && exp_q.size() == 0) break;
      tick();
    end
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] bits;
  int         nv0;
  int         ne0;

  initial begin
    reset_n    = 1'b0;
    meas_req   = 1'b0;
    meas_qubit = '0;
    res_valid  = 1'b0;
    res_bit    = 1'b0;
    err_clr    = 1'b0;
    #12;
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
    chk("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
    chk("rst_wr_data", {31'b0, wr_data}, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_err", {31'b0, err_orphan}, 32'd0);
    chk("rst_ready", {31'b0, meas_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // single write with exact phase timing
    exp_q.push_back('{a: 5'd7, d: 1'b1});
    meas_qubit = 5'd7;
    meas_req   = 1'b1;
    tick();
    meas_req = 1'b0;
    chk("single_pending1", 32'(pending), 32'd1);
    tick();
    chk("single_addr_en", {31'b0, wr_en}, 32'd1);
    chk("single_addr", {27'b0, wr_addr}, 32'd7);
    res_bit   = 1'b1;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("single_wait_en", {31'b0, wr_en}, 32'd0);
    chk("single_wait_val", {31'b0, wr_valid}, 32'd0);
    tick();
    chk("single_data_val", {31'b0, wr_valid}, 32'd1);
    chk("single_data", {31'b0, wr_data}, 32'd1);
    tick();
    chk("single_gap_val", {31'b0, wr_valid}, 32'd0);
    chk("single_gap_busy", {31'b0, busy}, 32'd1);
    chk("single_pending0", 32'(pending), 32'd0);
    tick();
    chk("single_idle", {31'b0, busy}, 32'd0);

    // early results, back-to-back spacing
    en_stamps.delete();
    send_req(5'd3, 1'b0);
    send_req(5'd9, 1'b1);
    send_res(1'b0);
    send_res(1'b1);
    wait_idle("early");
    chk("early_n_en", en_stamps.size(), 32'd2);
    if (en_stamps.size() == 2)
      chk("early_spacing", en_stamps[1] - en_stamps[0], 32'd4);

    // full boundary and pointer wrap
    bits = 6'b101101;
    for (int i = 0; i < 4; i++) send_req(5'(i), bits[i]);
    chk("full_pending", 32'(pending), 32'd4);
    chk("full_ready", {31'b0, meas_ready}, 32'd0);
    for (int i = 0; i < 4; i++) send_res(bits[i]);
    send_req(5'd4, bits[4]);
    send_req(5'd5, bits[5]);
    send_res(bits[4]);
    send_res(bits[5]);
    wait_idle("full");

    // orphan results and sticky error
    nv0 = n_val;
    send_res(1'b1);
    chk("orphan_set", {31'b0, err_orphan}, 32'd1);
    repeat (3) tick();
    chk("orphan_sticky", {31'b0, err_orphan}, 32'd1);
    chk("orphan_no_write", n_val, nv0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("orphan_clr", {31'b0, err_orphan}, 32'd0);
    res_valid = 1'b1;
    err_clr   = 1'b1;
    tick();
    res_valid = 1'b0;
    err_clr   = 1'b0;
    chk("orphan_set_wins", {31'b0, err_orphan}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("orphan_clr2", {31'b0, err_orphan}, 32'd0);
    exp_q.push_back('{a: 5'd12, d: 1'b1});
    meas_qubit = 5'd12;
    meas_req   = 1'b1;
    res_bit    = 1'b1;
    res_valid  = 1'b1;
    tick();
    meas_req  = 1'b0;
    res_valid = 1'b0;
    chk("pair_same_cycle_err", {31'b0, err_orphan}, 32'd0);
    wait_idle("pair");

    // reset during WAIT with two pending
    meas_qubit = 5'd1;
    meas_req   = 1'b1;
    tick();
    meas_qubit = 5'd2;
    tick();
    meas_req = 1'b0;
    tick();
    chk("mid_pending2", 32'(pending), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_en", {31'b0, wr_en}, 32'd0);
    chk("mid_rst_val", {31'b0, wr_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_pending0", 32'(pending), 32'd0);
    chk("mid_ready", {31'b0, meas_ready}, 32'd1);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    send_req(5'd20, 1'b0);
    send_res(1'b0);
    wait_idle("after_rst");

    // slow readout: stall in WAIT
    nv0 = n_val;
    send_req(5'd17, 1'b1);
    ne0 = en_stamps.size();
    repeat (20) tick();
    chk("slow_no_val", n_val, nv0);
    chk("slow_one_en", en_stamps.size(), ne0 + 1);
    chk("slow_busy", {31'b0, busy}, 32'd1);
    chk("slow_en_low", {31'b0, wr_en}, 32'd0);
    send_res(1'b1);
    wait_idle("slow");
    chk("slow_one_val", n_val, nv0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/q_ms_writer.md
# q_ms_writer

Producer side of the measurement-result register write protocol. Accepts measurement requests (target qubit index) from the instruction pipeline and discriminated readout bits from the readout path. Pairs them in order and drives the two-phase write handshake into the measurement register file: address phase `wr_en`/`wr_addr`, then data phase `wr_valid`/`wr_data`. Sits between the measure-instruction issue stage and the measurement register file.

## Interface
- `DEPTH`, 4: pending-measurement capacity (power of two, ≥2)
- `clk` in 1: clock; all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `meas_req` in 1: measurement request valid
- `meas_qubit` in 5: target qubit / register index
- `meas_ready` out 1: request accepted when `meas_req && meas_ready`
- `res_valid` in 1: readout result strobe, one cycle per result, in request order
- `res_bit` in 1: discriminated result bit
- `wr_en` out 1: address-phase strobe to the register file
- `wr_addr` out 5: register index; meaningful while `wr_en`=1
- `wr_valid` out 1: data-phase strobe to the register file
- `wr_data` out 1: result bit; meaningful while `wr_valid`=1
- `pending` out $clog2(DEPTH)+1: accepted requests not yet written
- `busy` out 1: `pending`≠0 or FSM≠IDLE
- `err_orphan` out 1: sticky; a result arrived with no outstanding request
- `err_clr` in 1: clears `err_orphan`

## Operation
- Address FIFO (DEPTH×5) is pushed on request acceptance. Result FIFO (DEPTH×1) is pushed on a paired `res_valid`. Both FIFOs pop together in DATA.
- `meas_ready` = address FIFO not full. It is combinational from the count and does not look ahead to a same-cycle pop.
- `outstanding` = requests accepted − results received, range 0..DEPTH.
- `res_valid` while `outstanding`=0 and no request is accepted in the same cycle: the result is dropped and `err_orphan` is set. A request and a result in the same cycle with `outstanding`=0 pair normally.
- The result FIFO cannot overflow, because results never exceed entries in the address FIFO.
- `err_clr` clears `err_orphan`. If an orphan occurs in the same cycle as `err_clr`, the set wins.
- FSM, Moore outputs, all outputs registered:
  - IDLE: → ADDR if address FIFO is non-empty.
  - ADDR: `wr_en`=1, `wr_addr`=address FIFO head. → WAIT.
  - WAIT: `wr_en`=0, `wr_valid`=0. → DATA when the result FIFO is non-empty.
  - DATA: `wr_valid`=1, `wr_data`=result FIFO head. Pop both FIFOs. → GAP.
  - GAP: both strobes 0. This is the recovery cycle the register file needs before its next address phase. → ADDR if address FIFO non-empty after the pop, else IDLE.
- `wr_en` and `wr_valid` are never high in the same cycle. Each is high for exactly one cycle per measurement.
- `wr_addr` and `wr_data` hold their last values when not strobed.
- `pending` decrements on the DATA pop.

## Timing
- Reset (asserted): FSM=IDLE; FIFOs and `outstanding` emptied. `wr_en`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `pending`=0, `err_orphan`=0, `meas_ready`=1.
- Asserting `reset_n` low mid-handshake drops strobes immediately. The register file is reset by its own reset; no partial write is replayed.
- Request accepted at edge N, result already queued, FSM IDLE:
  - `wr_en` high in cycle N+1.
  - WAIT in N+2.
  - `wr_valid` high in N+3.
- If a result arrives after WAIT is entered, `wr_valid` rises 1 cycle after the result is captured.
- Back-to-back throughput is one write per 4 cycles (ADDR, WAIT, DATA, GAP).
- Full boundary: at `pending`=DEPTH, `meas_ready`=0. It returns to 1 the cycle after the DATA pop.
- Pointers wrap modulo DEPTH; no special case at wrap.

## Test plan
- Single write: reset, request qubit 7, `res_bit`=1 two cycles later -> `wr_en`=1 with `wr_addr`=7 for one cycle, then `wr_valid`=1 with `wr_data`=1 for one cycle; `pending` returns to 0; `busy` drops after GAP.
- Early results: requests q3, q9 back-to-back, results 0, 1 on the next two cycles -> writes (3,0) then (9,1). `wr_en` spacing is exactly 4 cycles; strobes never overlap.
- Full/wrap: DEPTH=4, issue 6 requests for q0..q5 holding `meas_req` -> `meas_ready`=0 at `pending`=4; all 6 are written in order with correct bits once results are supplied.
- Orphan: `res_valid` with nothing outstanding -> no `wr_valid`, `err_orphan`=1 and sticky. `err_clr` clears it. A same-cycle request and result with `outstanding`=0 pair without error.
- Reset mid-operation: deassert `reset_n` during WAIT with 2 pending -> `wr_en`/`wr_valid` go to 0 asynchronously; `pending`=0 and `meas_ready`=1 after release; a new request is then written correctly.
- Slow readout: hold results for 20 cycles after ADDR -> FSM stays in WAIT with no strobes; a single `wr_valid` follows the result.
